// File: rtl/mac_vector_sequencer_if.sv
// Bundle of operand stream, MAC lane and result port signals for mac_vector_sequencer.
// The slave modport is the sequencer's view; master is the surrounding logic/testbench view.
interface mac_vector_sequencer_if #(
  parameter int DW   = 32,
  parameter int ACCW = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_a;
  logic [DW-1:0]   in_b;
  logic [DW-1:0]   mac_ain;
  logic [DW-1:0]   mac_bin;
  logic            mac_en;
  logic            mac_clr;
  logic [ACCW-1:0] mac_dout;
  logic            res_valid;
  logic            res_ready;
  logic [ACCW-1:0] res_data;
  logic            busy;
  logic [1:0]      dbg_state;

  modport slave (
    input  in_valid, in_a, in_b, mac_dout, res_ready,
    output in_ready, mac_ain, mac_bin, mac_en, mac_clr, res_valid, res_data, busy, dbg_state
  );

  modport master (
    output in_valid, in_a, in_b, mac_dout, res_ready,
    input  in_ready, mac_ain, mac_bin, mac_en, mac_clr, res_valid, res_data, busy, dbg_state
  );
endinterface

// File: rtl/mac_vector_sequencer.sv
// Feeds operand pairs from a skid FIFO into one MAC lane, VEC_LEN pairs per dot product,
// then captures the accumulated result and holds it on a valid/ready result port.
module mac_vector_sequencer #(
  parameter int DW         = 32,
  parameter int ACCW       = 64,
  parameter int VEC_LEN    = 8,
  parameter int MAC_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  mac_vector_sequencer_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = $clog2(VEC_LEN) + 1;
  localparam int LW = $clog2(MAC_LAT) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, FEED = 2'd1, DRAIN = 2'd2, HOLD = 2'd3} state_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // Sources keep valid and data stable until the transfer; in_ready depends on FIFO fullness
  // only, and res_valid/res_data stay fixed until res_ready is seen.
  state_t            state_q;
  logic [EW-1:0]     elem_cnt_q;
  logic [LW-1:0]     lat_cnt_q;
  logic [DW-1:0]     ain_q, bin_q;
  logic              en_q, clr_q, res_valid_q;
  logic [ACCW-1:0]   res_data_q;

  logic [DW-1:0]     mem_a [FIFO_DEPTH];
  logic [DW-1:0]     mem_b [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              full, empty, push, pop;

  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push    = bus.in_valid && !full;
  assign pop     = (state_q == FEED) && !empty;
  assign count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q] <= bus.in_a;
      mem_b[wr_ptr_q] <= bus.in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      elem_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      ain_q       <= '0;
      bin_q       <= '0;
      en_q        <= 1'b0;
      clr_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      en_q  <= 1'b0;
      clr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!empty) state_q <= FEED;
          else        clr_q   <= 1'b1;
        end
        FEED: begin
          if (!empty) begin
            ain_q <= mem_a[rd_ptr_q];
            bin_q <= mem_b[rd_ptr_q];
            en_q  <= 1'b1;
            if (elem_cnt_q == EW'(VEC_LEN - 1)) begin
              elem_cnt_q <= '0;
              state_q    <= DRAIN;
            end else begin
              elem_cnt_q <= elem_cnt_q + 1'b1;
            end
          end
        end
        // The first DRAIN cycle still carries the last mac_en; the sum settles MAC_LAT edges later.
        DRAIN: begin
          if (lat_cnt_q == LW'(MAC_LAT)) begin
            lat_cnt_q   <= '0;
            res_data_q  <= bus.mac_dout;
            res_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            clr_q       <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = !full;
  assign bus.mac_ain   = ain_q;
  assign bus.mac_bin   = bin_q;
  assign bus.mac_en    = en_q;
  assign bus.mac_clr   = clr_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.dbg_state = state_q;
endmodule
